rfsm: RTL and testbench

Read-side control FSM of the asynchronous FIFO, clocked in the read (output) domain. It consumes the write pointer synchronised into its domain, accepts `remove` requests, and drives the dual-port RAM read port with `rden` and `rdaddr`. It exports its own Gray-coded read pointer for synchronisation back into the write domain, and produces `empty`, `almost_empty`, an occupancy estimate, and a read-data valid strobe.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/g2b.sv | 21 ++
 rtl/rfsm.sv | 112 +++++++++++
 tb/tb_rfsm.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : state encoding and Gray helpers shared by the FIFO read/write FSMs
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_REMOVE = 2'b01,
    ST_IDLE   = 2'b10
  } fsm_state_t;

  // 32-bit helpers: zero-extended narrower pointers convert correctly
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/g2b.sv
// ============================================================================
// g2b : parameterised combinational Gray-to-binary converter
// Revision : 1.0
// ============================================================================
`default_nettype none

module g2b #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/rfsm.sv
// ============================================================================
// rfsm : read-side control FSM of the asynchronous FIFO (read clock domain)
// Revision : 1.0
// ============================================================================
`default_nettype none

module rfsm
  import fifo_pkg::*;
#(
  parameter int addrbits   = 8,
  parameter int almost_lvl = 4
) (
  input  logic                clk_out,
  input  logic                rst,
  input  logic                remove,
  input  logic                flush,
  input  logic [addrbits:0]   sync_wrptr,
  output logic                rden,
  output logic [addrbits-1:0] rdaddr,
  output logic [addrbits:0]   rdptr,
  output logic                empty,
  output logic                almost_empty,
  output logic [addrbits:0]   rcount,
  output logic                rvalid
);

  localparam int              PW  = addrbits + 1;
  localparam logic [addrbits:0] LVL = PW'(almost_lvl);

  fsm_state_t        state;
  fsm_state_t        state_next;
  logic [addrbits:0] rbin;
  logic [addrbits:0] rbinnext;
  logic [addrbits:0] rgraynext;
  logic [addrbits:0] wbin_s;
  logic [addrbits:0] cnt_next;
  logic              pop;
  logic              empty_val;
  logic              almost_val;

  assign pop       = remove & ~empty;
  assign rbinnext  = rbin + {{addrbits{1'b0}}, pop};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign rden      = pop & ~flush;
  assign rdaddr    = rbin[addrbits-1:0];

  g2b #(.WIDTH(PW)) u_g2b (
    .gray (sync_wrptr),
    .bin  (wbin_s)
  );

  // Lagging write pointer makes this count an underestimate, never an over-read
  assign empty_val  = (rgraynext == sync_wrptr);
  assign cnt_next   = wbin_s - rbinnext;
  assign almost_val = (cnt_next <= LVL);

  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) state <= ST_RESET;
    else      state <= state_next;
  end

  always_comb begin
    state_next = ST_IDLE;
    if (flush)    state_next = ST_RESET;
    else if (pop) state_next = ST_REMOVE;
    case (state)
      ST_RESET, ST_REMOVE, ST_IDLE: ;
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      rbin         <= '0;
      rdptr        <= '0;
      rcount       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      case (state_next)
        ST_RESET: begin
          rbin         <= '0;
          rdptr        <= '0;
          rcount       <= '0;
          empty        <= 1'b1;
          almost_empty <= 1'b1;
        end
        ST_REMOVE: begin
          rbin         <= rbinnext;
          rdptr        <= rgraynext;
          empty        <= empty_val;
          almost_empty <= almost_val;
          rcount       <= cnt_next;
        end
        default: begin
          empty        <= empty_val;
          almost_empty <= almost_val;
          rcount       <= cnt_next;
        end
      endcase
    end
  end

  // Not cleared by flush so an in-flight RAM read still delivers its data
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) rvalid <= 1'b0;
    else      rvalid <= rden;
  end

endmodule

`default_nettype wire

// File: tb/tb_rfsm.sv
// ============================================================================
// tb_rfsm : directed self-checking bench for rfsm (addrbits 8 and 3 instances)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rfsm;

  logic       clk_out = 1'b0;
  logic       rst     = 1'b0;

  logic       remove = 1'b0, flush = 1'b0;
  logic [8:0] sync_wrptr = '0;
  logic       rden, empty, almost_empty, rvalid;
  logic [7:0] rdaddr;
  logic [8:0] rdptr, rcount;

  logic       remove3 = 1'b0, flush3 = 1'b0;
  logic [3:0] sync_wrptr3 = '0;
  logic       rden3, empty3, almost_empty3, rvalid3;
  logic [2:0] rdaddr3;
  logic [3:0] rdptr3, rcount3;

  int total = 0;
  int bad   = 0;

  always #5 clk_out = ~clk_out;

  rfsm #(.addrbits(8), .almost_lvl(4)) dut (
    .clk_out(clk_out), .rst(rst), .remove(remove), .flush(flush),
    .sync_wrptr(sync_wrptr), .rden(rden), .rdaddr(rdaddr), .rdptr(rdptr),
    .empty(empty), .almost_empty(almost_empty), .rcount(rcount), .rvalid(rvalid)
  );

  rfsm #(.addrbits(3), .almost_lvl(4)) dut3 (
    .clk_out(clk_out), .rst(rst), .remove(remove3), .flush(flush3),
    .sync_wrptr(sync_wrptr3), .rden(rden3), .rdaddr(rdaddr3), .rdptr(rdptr3),
    .empty(empty3), .almost_empty(almost_empty3), .rcount(rcount3), .rvalid(rvalid3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  function automatic logic [8:0] g9(input int b);
    logic [8:0] v;
    v = b[8:0];
    return v ^ (v >> 1);
  endfunction

  function automatic logic [3:0] g4(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"},  empty, 1);
    chk({tag, "_almost"}, almost_empty, 1);
    chk({tag, "_rden"},   rden, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rdptr"},  rdptr, 0);
    chk({tag, "_rdaddr"}, rdaddr, 0);
    chk({tag, "_rcount"}, rcount, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    // power-on reset
    #7;
    chk_reset_vals("por");
    chk("por_empty3", empty3, 1);
    rst = 1'b1;
    tick();

    // three-entry drain
    sync_wrptr = 9'h002;
    tick();
    chk("drain_empty0", empty, 0);
    chk("drain_rcount3", rcount, 3);
    remove = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i < 3) begin
        chk("drain_rden", rden, 1);
        chk("drain_rdaddr", rdaddr, i);
      end else begin
        chk("drain_rden_off", rden, 0);
      end
      tick();
      chk("drain_rvalid", rvalid, (i < 3) ? 1 : 0);
      if (i == 2) begin
        chk("drain_empty1", empty, 1);
        chk("drain_rdptr", rdptr, 9'h002);
        chk("drain_rcount0", rcount, 0);
      end
    end

    // pop on empty
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("popempty_rden", rden, 0);
      tick();
      chk("popempty_rdptr", rdptr, 9'h002);
    end

    // flush together with remove, 10 entries with 4 popped
    rst = 1'b0; #1; rst = 1'b1;
    remove = 1'b0;
    sync_wrptr = g9(10);
    tick();
    chk("flush_empty0", empty, 0);
    chk("flush_rcount10", rcount, 10);
    remove = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("flush_pop_rden", rden, 1);
      chk("flush_pop_rdaddr", rdaddr, i);
      tick();
    end
    chk("flush_rdptr4", rdptr, g9(4));
    flush = 1'b1;
    #1;
    chk("flush_rden", rden, 0);
    chk("flush_rvalid_prev", rvalid, 1);
    tick();
    chk("flush_rdptr0", rdptr, 0);
    chk("flush_empty1", empty, 1);
    chk("flush_rcount0", rcount, 0);
    flush = 1'b0;
    tick();
    chk("postflush_empty0", empty, 0);
    #1;
    chk("postflush_rden", rden, 1);
    chk("postflush_rdaddr", rdaddr, 0);
    tick();
    chk("postflush_rdptr", rdptr, g9(1));

    // asynchronous reset mid-stream
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    rst = 1'b1;
    remove = 1'b0;

    // almost-empty threshold with 6 entries
    sync_wrptr = g9(6);
    tick();
    chk("ae_rcount6", rcount, 6);
    chk("ae_almost0", almost_empty, 0);
    chk("ae_empty0", empty, 0);
    remove = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("ae_rcount", rcount, 6 - i);
      chk("ae_almost", almost_empty, (6 - i <= 4) ? 1 : 0);
      chk("ae_empty", empty, (i == 6) ? 1 : 0);
    end
    remove = 1'b0;

    // wrap on the 3-bit instance: 40 entries, writer kept 3 ahead
    sync_wrptr3 = g4(3);
    tick();
    chk("wrap_empty0", empty3, 0);
    for (int i = 0; i < 40; i++) begin
      sync_wrptr3 = g4((i + 3 > 40) ? 40 : i + 3);
      remove3 = 1'b1;
      #1;
      chk("wrap_rden", rden3, 1);
      chk("wrap_rdaddr", rdaddr3, i % 8);
      tick();
      chk("wrap_rdptr", rdptr3, g4(i + 1));
    end
    chk("wrap_empty_end", empty3, 1);
    chk("wrap_rvalid_end", rvalid3, 1);
    #1;
    chk("wrap_rden_end", rden3, 0);
    remove3 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
